// File: rtl/dual_fetch_if.sv
// ----------------------------------------------------------------------------
// dual_fetch_if -- instruction-memory read bus used by dual_fetch.
//
// One request per cycle: imem_en/imem_addr are driven by the fetch unit, and
// the memory returns two consecutive words one cycle later.
//
//   imem_en      fetch -> mem   read request this cycle
//   imem_addr    fetch -> mem   word address of the request
//   imem_rdata0  mem -> fetch   mem[addr], valid the cycle after imem_en
//   imem_rdata1  mem -> fetch   mem[addr+1 mod 2^ADDR_WIDTH], same timing
//
// Modports: master = fetch unit, slave = memory.
// ----------------------------------------------------------------------------
interface dual_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  imem_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata0;
    logic [DATA_WIDTH-1:0] imem_rdata1;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata0,
        input  imem_rdata1
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata0,
        output imem_rdata1
    );
endinterface

// File: rtl/dual_fetch.sv
// ----------------------------------------------------------------------------
// dual_fetch -- two-word-per-cycle instruction fetch unit with a 4-entry
// buffer feeding two downstream lanes.
//
// Every request reads two consecutive words. Responses land in a circular
// 4-entry buffer; lane 1 shows the oldest word, lane 2 the next one. A request
// is issued only when the buffer is guaranteed to have room for the pair
// by the time it returns, so the buffer never overflows.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset (dominates flush)
//   flush         discard buffered and in-flight words, restart at redirect_pc
//   redirect_pc   restart address, sampled when flush=1
//   stall_in      downstream stall: bit0 blocks lane 1 (and thus lane 2),
//                 bit1 blocks lane 2 only
//   imem          dual_fetch_if.master: imem_en / imem_addr / imem_rdata0/1
//   valid1/data1  lane 1 word (data is 0 when invalid)
//   valid2/data2  lane 2 word (data is 0 when invalid)
//   pc1/pc2       word address of each lane (only with DUAL_FETCH_PC_TAG_EN,
//                 0 when the lane is invalid)
//
// Build option: define DUAL_FETCH_PC_TAG_EN to store a word address with every
// buffer entry and expose it on pc1/pc2. Undefined, those ports and the tag
// storage do not exist; everything else is identical.
// ----------------------------------------------------------------------------
module dual_fetch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic [1:0]            stall_in,
    dual_fetch_if.master          imem,
    output logic                  valid1,
    output logic                  valid2,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
`ifdef DUAL_FETCH_PC_TAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] pc1,
    output logic [ADDR_WIDTH-1:0] pc2
`endif
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q;        // address of the next request
    logic [2:0]            count_q;     // buffered words, 0..4
    logic [1:0]            rd_q;        // oldest entry (lane 1)
    logic [1:0]            wr_q;        // next free entry
    logic                  inflight_q;  // a response pair arrives this cycle
    logic [DATA_WIDTH-1:0] fifo_q [4];

`ifdef DUAL_FETCH_PC_TAG_EN
    logic [ADDR_WIDTH-1:0] tag_q [4];
    logic [ADDR_WIDTH-1:0] issue_pc_q;  // address of the pair now in flight
`endif

    // ------------------------------------------------------------------------
    // Pop / issue decision
    // ------------------------------------------------------------------------
    logic [1:0] stall_eff;
    logic [1:0] pops;
    logic [3:0] level_next;
    logic       issue;
    logic [1:0] rd_plus1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pops = 2'd0;

        // Lane 2 can never be taken without lane 1, so blocking lane 1 alone
        // means blocking both.
        stall_eff = stall_in[0] ? 2'b11 : stall_in;

        case (stall_eff)
            2'b00:   pops = (count_q >= 3'd2) ? 2'd2 : count_q[1:0];
            2'b10:   pops = (count_q != 3'd0) ? 2'd1 : 2'd0;
            default: pops = 2'd0;
        endcase

        // Occupancy after this edge: pops leave, any returning pair lands.
        level_next = {1'b0, count_q} - {2'b00, pops} + {2'b00, inflight_q, 1'b0};

        // A new pair returns one cycle later, so it needs two free entries
        // once this cycle's pops and writes have settled.
        issue = !rst && !flush && (level_next <= 4'd2);
    end

    assign rd_plus1       = rd_q + 2'd1;
    assign imem.imem_en   = issue;
    assign imem.imem_addr = pc_q;

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            count_q    <= 3'd0;
            rd_q       <= 2'd0;
            wr_q       <= 2'd0;
            inflight_q <= 1'b0;
        end else if (flush) begin
            // The returning pair (if any) is dropped by clearing inflight.
            pc_q       <= redirect_pc;
            count_q    <= 3'd0;
            rd_q       <= 2'd0;
            wr_q       <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            rd_q       <= rd_q + pops;
            count_q    <= level_next[2:0];
            inflight_q <= issue;
            if (inflight_q) begin
                wr_q <= wr_q + 2'd2;
            end
            if (issue) begin
                pc_q <= pc_q + ADDR_WIDTH'(2);
            end
        end
    end

`ifdef DUAL_FETCH_PC_TAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_pc_q <= RESET_PC;
        end else if (issue) begin
            issue_pc_q <= pc_q;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Buffer storage
    // ------------------------------------------------------------------------
    // NOTE: the buffer array is deliberately not reset; count_q gates every
    // read, so stale contents are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && !flush && inflight_q) begin
            fifo_q[wr_q]        <= imem.imem_rdata0;
            fifo_q[wr_q + 2'd1] <= imem.imem_rdata1;
`ifdef DUAL_FETCH_PC_TAG_EN
            tag_q[wr_q]         <= issue_pc_q;
            tag_q[wr_q + 2'd1]  <= issue_pc_q + ADDR_WIDTH'(1);
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Lane outputs
    // ------------------------------------------------------------------------
`ifdef DUAL_FETCH_PC_TAG_EN
    always_comb begin
        valid1 = (count_q != 3'd0);
        valid2 = (count_q >= 3'd2);
        data1  = valid1 ? fifo_q[rd_q]     : '0;
        data2  = valid2 ? fifo_q[rd_plus1] : '0;
        pc1    = valid1 ? tag_q[rd_q]      : '0;
        pc2    = valid2 ? tag_q[rd_plus1]  : '0;
    end
`else
    always_comb begin
        valid1 = (count_q != 3'd0);
        valid2 = (count_q >= 3'd2);
        data1  = valid1 ? fifo_q[rd_q]     : '0;
        data2  = valid2 ? fifo_q[rd_plus1] : '0;
    end
`endif

endmodule

// File: tb/tb_dual_fetch.sv
// ----------------------------------------------------------------------------
// tb_dual_fetch -- self-checking bench for dual_fetch.
//
// Memory holds mem[i] = 0x0100 + i. A queue-based reference model tracks the
// ordered stream of word addresses the DUT should be holding, plus the one
// request pair that may be in flight; expected lane contents and imem_en
// follow from queue size and the stall rules. Directed sequences cover
// start-up latency, stalls, flush and address wrap, followed by a random run.
// ----------------------------------------------------------------------------
module tb_dual_fetch;

    localparam int              DW       = 16;
    localparam int              AW       = 8;
    localparam logic [AW-1:0]   RESET_PC = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] redirect_pc;
    logic [1:0]    stall_in;
    logic          valid1, valid2;
    logic [DW-1:0] data1, data2;
`ifdef DUAL_FETCH_PC_TAG_EN
    logic [AW-1:0] pc1, pc2;
`endif

    always #5 clk = ~clk;

    dual_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .stall_in    (stall_in),
        .imem        (bus),
        .valid1      (valid1),
        .valid2      (valid2),
        .data1       (data1),
        .data2       (data2)
`ifdef DUAL_FETCH_PC_TAG_EN
        ,
        .pc1         (pc1),
        .pc2         (pc2)
`endif
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h0100 + {8'h00, a};
    endfunction

    // Memory: two consecutive words, one cycle after the request. Garbage
    // otherwise, so a write without a pending request is caught.
    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_rdata0 <= mem_word(bus.imem_addr);
            bus.imem_rdata1 <= mem_word(bus.imem_addr + 8'd1);
        end else begin
            bus.imem_rdata0 <= 16'hDEAD ^ DW'($urandom_range(0, 255));
            bus.imem_rdata1 <= 16'hBEEF ^ DW'($urandom_range(0, 255));
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [AW-1:0] mq[$];       // word addresses buffered, oldest first
    logic          m_pend;      // a pair will be written this cycle
    logic [AW-1:0] m_pend_addr;
    logic [AW-1:0] m_pc;
    logic          m_en;
    int            m_pops;

    // Drive inputs for one cycle and compare outputs against the model.
    task automatic begin_cycle(input logic r, input logic f,
                               input logic [AW-1:0] rp, input logic [1:0] st);
        int size;
        @(negedge clk);
        rst         = r;
        flush       = f;
        redirect_pc = rp;
        stall_in    = st;
        #1;
        size = mq.size();
        if (st[0])        m_pops = 0;                      // 01 and 11
        else if (st[1])   m_pops = (size >= 1) ? 1 : 0;    // 10
        else              m_pops = (size >= 2) ? 2 : size; // 00
        m_en = !r && !f && ((size - m_pops + (m_pend ? 2 : 0)) <= 2);

        check("imem_en", bus.imem_en, m_en);
        if (!r) begin
            check("imem_addr", bus.imem_addr, m_pc);
            check("valid1", valid1, size >= 1);
            check("valid2", valid2, size >= 2);
            check("data1", data1, (size >= 1) ? mem_word(mq[0]) : 16'h0);
            check("data2", data2, (size >= 2) ? mem_word(mq[1]) : 16'h0);
`ifdef DUAL_FETCH_PC_TAG_EN
            check("pc1", pc1, (size >= 1) ? mq[0] : 8'h0);
            check("pc2", pc2, (size >= 2) ? mq[1] : 8'h0);
`endif
        end
    endtask

    // Advance the model across the clock edge.
    task automatic end_cycle();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = RESET_PC;
        end else if (flush) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = redirect_pc;
        end else begin
            for (int i = 0; i < m_pops; i++) void'(mq.pop_front());
            if (m_pend) begin
                mq.push_back(m_pend_addr);
                mq.push_back(m_pend_addr + 8'd1);
            end
            m_pend      = m_en;
            m_pend_addr = m_pc;
            if (m_en) m_pc = m_pc + 8'd2;
        end
    endtask

    task automatic cycle(input logic r, input logic f,
                         input logic [AW-1:0] rp, input logic [1:0] st);
        begin_cycle(r, f, rp, st);
        end_cycle();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; flush = 1'b0; redirect_pc = '0; stall_in = 2'b00;
        m_pend = 1'b0; m_pend_addr = '0; m_pc = RESET_PC; m_en = 1'b0; m_pops = 0;

        // Reset for three cycles.
        repeat (3) cycle(1'b1, 1'b0, 8'h00, 2'b00);

        // Start-up latency and first words.
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);          // cycle 1
        check("c1_en", bus.imem_en, 1'b1);
        check("c1_addr", bus.imem_addr, 8'h00);
        check("c1_valid1", valid1, 1'b0);
        end_cycle();
        cycle(1'b0, 1'b0, 8'h00, 2'b00);                // cycle 2
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);          // cycle 3
        check("c3_data1", data1, 16'h0100);
        check("c3_data2", data2, 16'h0101);
        end_cycle();
        cycle(1'b0, 1'b0, 8'h00, 2'b00);                // cycle 4

        // Single pop, then a 01 stall that must pop nothing.
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b10);          // cycle 5
        check("pop1_before_d1", data1, 16'h0104);
        check("pop1_before_d2", data2, 16'h0105);
        end_cycle();
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b01);          // cycle 6
        check("pop1_after_d1", data1, 16'h0105);
        end_cycle();
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);          // cycle 7
        check("stall01_d1", data1, 16'h0105);
        end_cycle();

        // Full stall for four cycles, then release.
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 2'b00);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 2'b11);
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b11);
        check("stall_full_en", bus.imem_en, 1'b0);
        check("stall_full_v2", valid2, 1'b1);
        end_cycle();
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 2'b00);

        // Flush with a response in flight.
        begin_cycle(1'b0, 1'b1, 8'h40, 2'b00);
        end_cycle();
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);
        check("flush_v1", valid1, 1'b0);
        check("flush_v2", valid2, 1'b0);
        check("flush_addr", bus.imem_addr, 8'h40);
        check("flush_en", bus.imem_en, 1'b1);
        end_cycle();
        cycle(1'b0, 1'b0, 8'h00, 2'b00);
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);
        check("flush_d1", data1, 16'h0140);
        check("flush_d2", data2, 16'h0141);
        end_cycle();

        // Redirect to the last address: wrap to word 0.
        cycle(1'b0, 1'b1, 8'hFF, 2'b00);
        cycle(1'b0, 1'b0, 8'h00, 2'b00);
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);
        check("wrap_next_addr", bus.imem_addr, 8'h01);
        end_cycle();
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);
        check("wrap_d1", data1, 16'h01FF);
        check("wrap_d2", data2, 16'h0100);
`ifdef DUAL_FETCH_PC_TAG_EN
        check("wrap_pc1", pc1, 8'hFF);
        check("wrap_pc2", pc2, 8'h00);
`endif
        end_cycle();

        // Reset mid-stream, then resume.
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 2'b00);
        cycle(1'b1, 1'b1, 8'h80, 2'b00);
        begin_cycle(1'b0, 1'b0, 8'h00, 2'b00);
        check("midrst_addr", bus.imem_addr, RESET_PC);
        check("midrst_v1", valid1, 1'b0);
        end_cycle();

        // Random run.
        for (int i = 0; i < 600; i++) begin
            logic r, f;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 6);
            cycle(r, f, AW'($urandom), 2'($urandom));
        end

        // Drain and finish.
        repeat (4) cycle(1'b0, 1'b0, 8'h00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
